restoring_divider: RTL
======================

Name: restoring_divider

Overview:
- Sequential unsigned integer divider: quotient = dividend / divisor, remainder = dividend % divisor, one quotient bit resolved per cycle.
- Subtraction is the inverse of the team's look-ahead adder. This block reuses the same generate/propagate look-ahead style on the borrow chain inside a combinational subtractor sub-module.
- Sits beside the arithmetic datapath blocks. A controller drives it with a single-cycle start pulse and waits for a done pulse.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits; 1 to 8 are valid.

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  reset, synchronous, active-low
- start_in  input  1  request pulse; sampled only when not busy
- dividend_in  input  DATA_WIDTH  unsigned dividend, captured when start is accepted
- divisor_in  input  DATA_WIDTH  unsigned divisor, captured when start is accepted
- busy_out  output  1  high while an operation is in progress
- done_out  output  1  one-cycle pulse when results become valid
- quotient_out  output  DATA_WIDTH  quotient; held until next accepted start
- remainder_out  output  DATA_WIDTH  remainder; held until next accepted start
- div_by_zero_out  output  1  high with results when captured divisor was 0; held like results

Behaviour:
- Reset (rst_n_in low at a rising edge): FSM goes to IDLE and every output is 0, including quotient, remainder, busy, done and div_by_zero. Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE, start_in=1:
  - Capture the operands. Clear div_by_zero_out, busy_out=1 from the next cycle.
  - If divisor_in==0, go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise load the working regs: rem=0, quo=dividend, iteration counter=0. Go to CALC.
- CALC, each cycle:
  - shifted = {rem, quo[MSB]} (DATA_WIDTH+1 bits). trial = shifted − {0, divisor}, computed by the sub-module.
  - No borrow: rem = trial[DATA_WIDTH-1:0] and the new quo LSB = 1. Borrow: rem = shifted[DATA_WIDTH-1:0] and the new quo LSB = 0. quo shifts left by 1 in both cases.
  - The counter increments. After the DATA_WIDTH-th iteration, go to DONE.
- DONE (exactly one cycle):
  - done_out=1, busy_out=0, and quotient/remainder outputs are valid. Outputs are registered, so they are valid in the same cycle as done_out.
  - Next state is IDLE.
  - start_in in the DONE cycle is accepted exactly as in IDLE (back-to-back operation).
- Latency, from the edge that accepts start: done_out is high in the cycle following edge DATA_WIDTH+1. For divide-by-zero it is high in the cycle following edge 1.
- start_in while in CALC is ignored; operands and state are unaffected.
- Result outputs change only on entry to DONE or on reset. They are never X, and they stay stable during a subsequent CALC.
- Arithmetic is fully unsigned. The remainder is always less than a nonzero divisor. The quotient cannot overflow for DATA_WIDTH bits.

Decomposition:
- Shared package div_pkg holds:
  - the state typedef (IDLE, CALC, DONE);
  - the counter width constant, $clog2(DATA_WIDTH+1);
  - DIV_ZERO_QUOTIENT, defined as all ones.
- Sub-module borrow_look_ahead_subtractor:
  - Parameter WIDTH. Ports a_in, b_in, borrow_in, diff_out, borrow_out.
  - Borrow generate g=~a&b and propagate p=~(a^b), with a look-ahead borrow chain.
  - Purely combinational. Instantiated with WIDTH=DATA_WIDTH+1 and borrow_in=0.

Test Plan (DATA_WIDTH=8):
- 200/7: start pulse → done_out high in the cycle after edge 9; quotient=28, remainder=4, div_by_zero=0, busy high for cycles 1–8.
- 255/1 then 5/9: start issued in the DONE cycle of the first operation → first gives 255 r0. Second is accepted immediately, giving 0 r5, with done 9 cycles later.
- 100/0: start → done in the cycle after edge 1; quotient=0xFF, remainder=100, div_by_zero=1. A following 9/3 clears the flag and gives 3 r0.
- 0/13 and 13/13: → 0 r0 and 1 r0 respectively.
- start_in held high throughout 150/4 → exactly one operation, giving 37 r2. Operands changed mid-CALC have no effect.
- rst_n_in low at cycle 4 of 77/5 → all outputs 0 on the next cycle, with no done pulse. A fresh 77/5 then gives 15 r2.
- Exhaustive random sweep of all dividend/divisor pairs → every result matches the reference model.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the restoring divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int MAX_DATA_WIDTH = 8;
  localparam int CNT_WIDTH      = $clog2(MAX_DATA_WIDTH + 1);

  localparam logic [MAX_DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/borrow_look_ahead_subtractor.sv
// rtl/borrow_look_ahead_subtractor.sv - combinational a - b with look-ahead borrow chain
module borrow_look_ahead_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   borrow;

  assign g = ~a_in & b_in;
  assign p = ~(a_in ^ b_in);

  // Each borrow is a flat sum of products over all lower generate/propagate
  // terms rather than a ripple through the previous stage's borrow.
  always_comb begin
    logic carry;
    logic prop;
    carry     = 1'b0;
    prop      = 1'b1;
    borrow    = '0;
    borrow[0] = borrow_in;
    for (int i = 0; i < WIDTH; i++) begin
      carry = 1'b0;
      prop  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        carry = carry | (g[j] & prop);
        prop  = prop & p[j];
      end
      borrow[i+1] = carry | (prop & borrow_in);
    end
  end

  assign diff_out   = a_in ^ b_in ^ borrow[WIDTH-1:0];
  assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per cycle
module restoring_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] dividend_in,
  input  logic [DATA_WIDTH-1:0] divisor_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] quotient_out,
  output logic [DATA_WIDTH-1:0] remainder_out,
  output logic                  div_by_zero_out
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic                  borrow;
  logic [DATA_WIDTH:0]   quo_ext;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic                  last_iter;
  logic                  unused_bits;

  assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};

  borrow_look_ahead_subtractor #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_sub (
    .a_in      (shifted),
    .b_in      ({1'b0, div_q}),
    .borrow_in (1'b0),
    .diff_out  (trial),
    .borrow_out(borrow)
  );

  // A borrow means the trial subtraction failed, so the shifted value is restored.
  assign rem_next    = borrow ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  assign quo_ext     = {quo_q, ~borrow};
  assign quo_next    = quo_ext[DATA_WIDTH-1:0];
  assign last_iter   = (cnt_q == LAST_ITER);
  assign unused_bits = ^{shifted[DATA_WIDTH], trial[DATA_WIDTH], quo_ext[DATA_WIDTH]};

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_out = 1'b0;
    done_out = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_out = (state_q == DONE);
        state_d  = IDLE;
        if (start_in) begin
          state_d = (divisor_in == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy_out = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rem_q           <= '0;
      quo_q           <= '0;
      div_q           <= '0;
      cnt_q           <= '0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_in) begin
            div_q           <= divisor_in;
            cnt_q           <= '0;
            div_by_zero_out <= 1'b0;
            if (divisor_in == '0) begin
              quotient_out    <= DIV_ZERO_QUOTIENT[DATA_WIDTH-1:0];
              remainder_out   <= dividend_in;
              div_by_zero_out <= 1'b1;
            end else begin
              rem_q <= '0;
              quo_q <= dividend_in;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            quotient_out  <= quo_next;
            remainder_out <= rem_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
